// File: rtl/reg_alu_pkg.sv
// rtl/reg_alu_pkg.sv - shared types and constants for the reg_alu datapath and its controller
package reg_alu_pkg;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int OW = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_READBACK = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  localparam logic KIND_ALU = 1'b0;
  localparam logic KIND_LDI = 1'b1;

  localparam logic SEL_ALU = 1'b1;
  localparam logic SEL_DIN = 1'b0;

endpackage

// File: rtl/reg16.sv
// rtl/reg16.sv - 16-bit load-enable register with synchronous active-high reset
module reg16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] d,
  output logic [15:0] q
);

  // Hold value until load; reset clears.
  always_ff @(posedge clk) begin
    if (reset)
      q <= 16'h0000;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/reg_alu_ctrl.sv
// rtl/reg_alu_ctrl.sv - command sequencer driving the reg_alu register file / ALU
module reg_alu_ctrl
  import reg_alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_kind,
  input  logic [OW-1:0] cmd_op,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [AW-1:0] cmd_rd,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic          wr,
  output logic [AW-1:0] wr_addr,
  output logic          sel,
  output logic [OW-1:0] op,
  output logic [DW-1:0] d_in,
  input  logic [DW-1:0] rf_d_out_a,
  input  logic          rf_cout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_carry
);

  state_t        state, state_nxt;
  logic          kind_q;
  logic [OW-1:0] op_q;
  logic [AW-1:0] ra_q, rb_q, rd_q;
  logic [DW-1:0] imm_q;
  logic          carry_q;
  logic          accept;

  assign accept    = (state == ST_IDLE) && cmd_valid;
  assign rsp_carry = carry_q;

  // State register; reset wins in every state, so an in-flight command is simply dropped.
  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Latch command fields on accept and the ALU carry during the write cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q  <= KIND_ALU;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      if (accept) begin
        kind_q <= cmd_kind;
        op_q   <= cmd_op;
        ra_q   <= cmd_ra;
        rb_q   <= cmd_rb;
        rd_q   <= cmd_rd;
        imm_q  <= cmd_imm;
      end
      if (state == ST_EXEC)
        carry_q <= (kind_q == KIND_ALU) ? rf_cout : 1'b0;
    end
  end

  // Response data is the destination register read back after the write has landed.
  reg16 u_rsp_data (
    .clk   (clk),
    .reset (reset),
    .load  (state == ST_READBACK),
    .d     (rf_d_out_a),
    .q     (rsp_data)
  );

  // Next-state and datapath control; everything idles at zero outside its active state.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    wr        = 1'b0;
    wr_addr   = '0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    sel       = SEL_DIN;
    op        = '0;
    d_in      = '0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid)
          state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        wr        = 1'b1;
        wr_addr   = rd_q;
        rd_addr_a = ra_q;
        rd_addr_b = rb_q;
        op        = op_q;
        if (kind_q == KIND_ALU) begin
          sel = SEL_ALU;
        end else begin
          sel  = SEL_DIN;
          d_in = imm_q;
        end
        state_nxt = ST_READBACK;
      end
      ST_READBACK: begin
        rd_addr_a = rd_q;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
